// File: rtl/fwd_src_pipe.sv
// Producer side of the forwarding interface: tracks rd, result class and result data of the
// instructions in EX, MEM and WB, and owns the load handshake that freezes EX/MEM.
module fwd_src_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [REGW-1:0] id_rd_i,
  input  logic            id_wen_i,
  input  logic            id_is_load_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [REGW-1:0] ex_rd_o,
  output logic [1:0]      ex_inst_o,
  output logic [XLEN-1:0] ex_dat_o,
  output logic [REGW-1:0] mem_rd_o,
  output logic [1:0]      mem_inst_o,
  output logic [XLEN-1:0] mem_dat_o,
  output logic            mem_ack_o,
  output logic            mem_req_o,
  output logic            mem_busy_o,
  output logic [REGW-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_dat_o,
  output logic            wb_we_o
);

  localparam logic [1:0] ClsNone = 2'b00;
  localparam logic [1:0] ClsAlu  = 2'b01;
  localparam logic [1:0] ClsLoad = 2'b10;

  typedef enum logic [0:0] {StIdle, StWait} load_st_e;

  load_st_e        load_st_q, load_st_d;
  logic [REGW-1:0] ex_rd_q, ex_rd_d;
  logic [1:0]      ex_inst_q, ex_inst_d;
  logic [REGW-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]      mem_inst_q, mem_inst_d;
  logic [XLEN-1:0] mem_alu_q, mem_alu_d;
  logic [REGW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_dat_q, wb_dat_d;

  logic            id_track;
  logic [REGW-1:0] entry_rd;
  logic [1:0]      entry_inst;
  logic            hold;

  // Instructions that do not write, or write x0, never become forwarding sources.
  assign id_track   = id_valid_i & id_wen_i & (id_rd_i != '0);
  assign entry_rd   = id_track ? id_rd_i : '0;
  assign entry_inst = !id_track ? ClsNone : (id_is_load_i ? ClsLoad : ClsAlu);

  assign hold       = (load_st_q == StWait) & ~mem_ack_i;
  assign mem_req_o  = (load_st_q == StWait);
  assign mem_busy_o = hold;
  assign mem_ack_o  = mem_ack_i & (load_st_q == StWait);

  assign ex_rd_o    = ex_rd_q;
  assign ex_inst_o  = ex_inst_q;
  assign ex_dat_o   = (ex_inst_q == ClsAlu) ? ex_result_i : '0;

  assign mem_rd_o   = mem_rd_q;
  assign mem_inst_o = mem_inst_q;
  assign mem_dat_o  = (mem_inst_q == ClsLoad) ? mem_rdata_i : mem_alu_q;

  assign wb_rd_o    = wb_rd_q;
  assign wb_dat_o   = wb_dat_q;
  assign wb_we_o    = (wb_rd_q != '0);

  // Load handshake: WAIT exactly while a load sits in MEM.
  always_comb begin
    load_st_d = load_st_q;
    unique case (load_st_q)
      StIdle: begin
        if (ex_inst_q == ClsLoad) load_st_d = StWait;
      end
      StWait: begin
        if (mem_ack_i) load_st_d = (ex_inst_q == ClsLoad) ? StWait : StIdle;
      end
      default: load_st_d = StIdle;
    endcase
  end

  always_comb begin
    ex_rd_d    = ex_rd_q;
    ex_inst_d  = ex_inst_q;
    mem_rd_d   = mem_rd_q;
    mem_inst_d = mem_inst_q;
    mem_alu_d  = mem_alu_q;
    wb_rd_d    = '0;
    wb_dat_d   = '0;
    if (!hold) begin
      wb_rd_d    = mem_rd_q;
      wb_dat_d   = mem_dat_o;
      mem_rd_d   = ex_rd_q;
      mem_inst_d = ex_inst_q;
      mem_alu_d  = ex_dat_o;
      if (flush_i || stall_i) begin
        ex_rd_d   = '0;
        ex_inst_d = ClsNone;
      end else begin
        ex_rd_d   = entry_rd;
        ex_inst_d = entry_inst;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_st_q  <= StIdle;
      ex_rd_q    <= '0;
      ex_inst_q  <= ClsNone;
      mem_rd_q   <= '0;
      mem_inst_q <= ClsNone;
      mem_alu_q  <= '0;
      wb_rd_q    <= '0;
      wb_dat_q   <= '0;
    end else begin
      load_st_q  <= load_st_d;
      ex_rd_q    <= ex_rd_d;
      ex_inst_q  <= ex_inst_d;
      mem_rd_q   <= mem_rd_d;
      mem_inst_q <= mem_inst_d;
      mem_alu_q  <= mem_alu_d;
      wb_rd_q    <= wb_rd_d;
      wb_dat_q   <= wb_dat_d;
    end
  end

endmodule
